clip_obj_table: RTL and testbench

Object store that feeds the clipper's refresh sequencer. It holds up to 32 objects of 4 points each and stages host point writes into a shadow buffer. It commits each object atomically and exports `obj_map`, `changed` and `writing` to the clipping timing logic. During refresh it serves point reads addressed by that logic's `addr` and cycle count.

---
 rtl/clip_obj_table_if.sv | 23 ++
 rtl/clip_obj_table.sv | 163 ++++++++++++++++
 tb/tb_clip_obj_table.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clip_obj_table_if.sv
// Host command port of the clipper object store: staged point writes,
// commit/delete/clear commands, the ready handshake and the reject pulse.
interface clip_obj_table_if #(
  parameter int PT_W = 48
);
  logic            cmd_vld;
  logic            cmd_rdy;
  logic [1:0]      cmd_op;
  logic [4:0]      cmd_obj;
  logic [1:0]      cmd_pt;
  logic [PT_W-1:0] cmd_data;
  logic            cmd_err;

  modport master (
    output cmd_vld, cmd_op, cmd_obj, cmd_pt, cmd_data,
    input  cmd_rdy, cmd_err
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_obj, cmd_pt, cmd_data,
    output cmd_rdy, cmd_err
  );
endinterface

// File: rtl/clip_obj_table.sv
// Object store for the clipper refresh sequencer: 32 objects x 4 points,
// host writes go through a shadow buffer and land atomically on commit.
module clip_obj_table #(
  parameter int PT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  clip_obj_table_if.slave  cmd,
  input  logic             i_clr_changed,
  input  logic [4:0]       i_rd_addr,
  input  logic [1:0]       i_rd_pt,
  output logic [PT_W-1:0]  o_rd_data,
  output logic [31:0]      o_obj_map,
  output logic             o_changed,
  output logic             o_writing
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STAGING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_STAGE  = 2'b00,
    OP_COMMIT = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [3:0]            r_stage_mask;
  logic [3:0][PT_W-1:0]  r_staging;
  logic [3:0][PT_W-1:0]  r_table [0:31];
  logic [4:0]            r_commit_obj;
  logic [31:0]           r_obj_map;
  logic                  r_changed;
  logic                  r_cmd_err;
  logic [PT_W-1:0]       r_rd_data;

  op_e  w_op;
  logic w_accept;
  logic w_commit_now;
  logic w_stage_we;
  logic w_commit_go;
  logic w_commit_err;
  logic w_delete;
  logic w_clear_all;
  logic w_set_changed;

  assign w_op          = op_e'(cmd.cmd_op);
  assign w_commit_now  = (r_state == ST_COMMIT);
  assign w_accept      = cmd.cmd_vld && !w_commit_now;
  assign w_set_changed = w_commit_now || w_delete || w_clear_all;

  assign cmd.cmd_rdy = !w_commit_now;
  assign cmd.cmd_err = r_cmd_err;
  assign o_writing   = w_commit_now;
  assign o_obj_map   = r_obj_map;
  assign o_changed   = r_changed;
  assign o_rd_data   = r_rd_data;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path
  // through the case statements can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_stage_we   = 1'b0;
    w_commit_go  = 1'b0;
    w_commit_err = 1'b0;
    w_delete     = 1'b0;
    w_clear_all  = 1'b0;
    case (r_state)
      ST_COMMIT: w_state_next = ST_IDLE;
      default: begin
        if (w_accept) begin
          case (w_op)
            OP_STAGE: begin
              w_stage_we   = 1'b1;
              w_state_next = ST_STAGING;
            end
            OP_COMMIT: begin
              if (r_stage_mask == 4'hF) begin
                w_commit_go  = 1'b1;
                w_state_next = ST_COMMIT;
              end else begin
                w_commit_err = 1'b1;
              end
            end
            OP_DELETE: w_delete = 1'b1;
            OP_CLEAR: begin
              w_clear_all  = 1'b1;
              w_state_next = ST_IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // Control and status registers. A set of the changed flag outranks a
  // same-cycle clear so a modification during end-of-refresh is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_mask <= '0;
      r_commit_obj <= '0;
      r_obj_map    <= '0;
      r_changed    <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_cmd_err <= w_commit_err;
      r_rd_data <= r_table[i_rd_addr][i_rd_pt];

      if (w_stage_we) begin
        r_stage_mask[cmd.cmd_pt] <= 1'b1;
      end
      if (w_commit_go) begin
        r_commit_obj <= cmd.cmd_obj;
      end
      if (w_commit_now) begin
        r_stage_mask              <= '0;
        r_obj_map[r_commit_obj]   <= 1'b1;
      end
      if (w_delete) begin
        r_obj_map[cmd.cmd_obj] <= 1'b0;
      end
      if (w_clear_all) begin
        r_obj_map    <= '0;
        r_stage_mask <= '0;
      end

      if (w_set_changed) begin
        r_changed <= 1'b1;
      end else if (i_clr_changed) begin
        r_changed <= 1'b0;
      end
    end
  end

  // NOTE: point storage is deliberately left out of reset; obj_map alone
  // says which entries are valid, and reset forces the FSM out of COMMIT
  // so no table write can happen while rst_n is low.
  always_ff @(posedge clk) begin
    if (w_stage_we) begin
      r_staging[cmd.cmd_pt] <= cmd.cmd_data;
    end
    if (w_commit_now) begin
      r_table[r_commit_obj] <= r_staging;
    end
  end

endmodule

// File: tb/tb_clip_obj_table.sv
// Bench for clip_obj_table: directed vector table for the commit/read timing
// corners, a reset-abort sequence, then random traffic against a model.
module tb_clip_obj_table;

  localparam int PT_W = 48;
  typedef logic [PT_W-1:0] pt_t;

  typedef struct {
    logic        vld;
    logic [1:0]  op;
    logic [4:0]  obj;
    logic [1:0]  pt;
    pt_t         data;
    logic        clr;
    logic [4:0]  ra;
    logic [1:0]  rp;
    logic        rdy;
    logic        wr;
    logic        err;
    logic [31:0] map;
    logic        chg;
    logic        chk;
    pt_t         rd;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clr_changed;
  logic [4:0]  rd_addr;
  logic [1:0]  rd_pt;
  pt_t         rd_data;
  logic [31:0] obj_map;
  logic        changed;
  logic        writing;

  int total;
  int bad;

  clip_obj_table_if #(.PT_W(PT_W)) bus ();

  clip_obj_table #(.PT_W(PT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (bus),
    .i_clr_changed(clr_changed),
    .i_rd_addr    (rd_addr),
    .i_rd_pt      (rd_pt),
    .o_rd_data    (rd_data),
    .o_obj_map    (obj_map),
    .o_changed    (changed),
    .o_writing    (writing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the table as plain arrays, a pending-commit flag and
  // per-entry knowledge of whether the stored points are defined.
  pt_t         m_tab [32][4];
  bit          m_known [32];
  pt_t         m_stg [4];
  bit [3:0]    m_mask;
  bit          m_pend;
  logic [4:0]  m_pobj;
  bit          m_err;
  bit [31:0]   m_map;
  bit          m_chg;
  pt_t         m_rd;
  bit          m_rd_ok;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    if (m_pend) m_known[m_pobj] = 1'b0;
    m_mask  = '0;
    m_pend  = 1'b0;
    m_err   = 1'b0;
    m_map   = '0;
    m_chg   = 1'b0;
    m_rd    = '0;
    m_rd_ok = 1'b1;
  endtask

  task automatic model_step();
    pt_t nrd;
    bit  nok;
    bit  set_c;
    nrd   = m_tab[rd_addr][rd_pt];
    nok   = m_known[rd_addr];
    set_c = 1'b0;
    m_err = 1'b0;
    if (m_pend) begin
      for (int p = 0; p < 4; p++) m_tab[m_pobj][p] = m_stg[p];
      m_known[m_pobj] = 1'b1;
      m_map[m_pobj]   = 1'b1;
      m_mask          = '0;
      m_pend          = 1'b0;
      set_c           = 1'b1;
    end else if (bus.cmd_vld) begin
      case (bus.cmd_op)
        2'b00: begin
          m_stg[bus.cmd_pt]  = bus.cmd_data;
          m_mask[bus.cmd_pt] = 1'b1;
        end
        2'b01: begin
          if (m_mask == 4'hF) begin
            m_pend = 1'b1;
            m_pobj = bus.cmd_obj;
          end else begin
            m_err = 1'b1;
          end
        end
        2'b10: begin
          m_map[bus.cmd_obj] = 1'b0;
          set_c = 1'b1;
        end
        default: begin
          m_map  = '0;
          m_mask = '0;
          set_c  = 1'b1;
        end
      endcase
    end
    if (set_c) m_chg = 1'b1;
    else if (clr_changed) m_chg = 1'b0;
    m_rd    = nrd;
    m_rd_ok = nok;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " rdy"}, 64'(bus.cmd_rdy), 64'(!m_pend));
    check({tag, " writing"}, 64'(writing), 64'(m_pend));
    check({tag, " err"}, 64'(bus.cmd_err), 64'(m_err));
    check({tag, " map"}, 64'(obj_map), 64'(m_map));
    check({tag, " changed"}, 64'(changed), 64'(m_chg));
    if (m_rd_ok) check({tag, " rd_data"}, 64'(rd_data), 64'(m_rd));
  endtask

  task automatic drv(input logic vld, input logic [1:0] op, input logic [4:0] obj,
                     input logic [1:0] pt, input pt_t data, input logic clr,
                     input logic [4:0] ra, input logic [1:0] rp);
    bus.cmd_vld  = vld;
    bus.cmd_op   = op;
    bus.cmd_obj  = obj;
    bus.cmd_pt   = pt;
    bus.cmd_data = data;
    clr_changed  = clr;
    rd_addr      = ra;
    rd_pt        = rp;
  endtask

  function automatic vec_t mk(input logic vld, input logic [1:0] op, input logic [4:0] obj,
                              input logic [1:0] pt, input pt_t data, input logic clr,
                              input logic rdy, input logic wr, input logic err,
                              input logic [31:0] map, input logic chg);
    vec_t v;
    v.vld = vld; v.op = op; v.obj = obj; v.pt = pt; v.data = data; v.clr = clr;
    v.ra = '0; v.rp = '0;
    v.rdy = rdy; v.wr = wr; v.err = err; v.map = map; v.chg = chg;
    v.chk = 1'b0; v.rd = '0;
    return v;
  endfunction

  function automatic vec_t stg(input logic [1:0] pt, input pt_t d, input logic [31:0] map, input logic chg);
    return mk(1'b1, 2'b00, 5'd0, pt, d, 1'b0, 1'b1, 1'b0, 1'b0, map, chg);
  endfunction

  function automatic vec_t cmt(input logic [4:0] obj, input logic [31:0] map, input logic chg,
                               input logic wr, input logic err);
    return mk(1'b1, 2'b01, obj, 2'd0, '0, 1'b0, !wr, wr, err, map, chg);
  endfunction

  function automatic vec_t del(input logic [4:0] obj, input logic [31:0] map, input logic chg);
    return mk(1'b1, 2'b10, obj, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0, map, chg);
  endfunction

  function automatic vec_t clra(input logic [31:0] map, input logic chg);
    return mk(1'b1, 2'b11, 5'd0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0, map, chg);
  endfunction

  function automatic vec_t idl(input logic clr, input logic [31:0] map, input logic chg);
    return mk(1'b0, 2'b00, 5'd0, 2'd0, '0, clr, 1'b1, 1'b0, 1'b0, map, chg);
  endfunction

  function automatic vec_t with_rd(input vec_t v, input logic [4:0] ra, input logic [1:0] rp, input pt_t rd);
    vec_t r;
    r     = v;
    r.ra  = ra;
    r.rp  = rp;
    r.chk = 1'b1;
    r.rd  = rd;
    return r;
  endfunction

  vec_t vq[$];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drv(1'b0, 2'b00, 5'd0, 2'd0, '0, 1'b0, 5'd0, 2'd0);

    // Commit of obj 5 and readback.
    vq.push_back(stg(2'd0, 48'h1, 32'h0, 1'b0));
    vq.push_back(stg(2'd1, 48'h2, 32'h0, 1'b0));
    vq.push_back(stg(2'd2, 48'h3, 32'h0, 1'b0));
    vq.push_back(stg(2'd3, 48'h4, 32'h0, 1'b0));
    vq.push_back(cmt(5'd5, 32'h0, 1'b0, 1'b1, 1'b0));
    vq.push_back(idl(1'b0, 32'h20, 1'b1));
    vq.push_back(with_rd(idl(1'b0, 32'h20, 1'b1), 5'd5, 2'd2, 48'h3));
    vq.push_back(idl(1'b1, 32'h20, 1'b0));
    // Incomplete commit rejected, then completed; commit lands with clr_changed.
    vq.push_back(stg(2'd0, 48'h10, 32'h20, 1'b0));
    vq.push_back(stg(2'd1, 48'h11, 32'h20, 1'b0));
    vq.push_back(stg(2'd3, 48'h13, 32'h20, 1'b0));
    vq.push_back(cmt(5'd7, 32'h20, 1'b0, 1'b0, 1'b1));
    vq.push_back(stg(2'd2, 48'h12, 32'h20, 1'b0));
    vq.push_back(cmt(5'd7, 32'h20, 1'b0, 1'b1, 1'b0));
    vq.push_back(idl(1'b1, 32'hA0, 1'b1));
    vq.push_back(with_rd(idl(1'b1, 32'hA0, 1'b0), 5'd7, 2'd3, 48'h13));
    // Objects 0 and 31, delete, repeated delete, clear-all, stale commit.
    for (int p = 0; p < 4; p++) vq.push_back(stg(2'(p), 48'h100 + 48'(p), 32'hA0, 1'b0));
    vq.push_back(cmt(5'd0, 32'hA0, 1'b0, 1'b1, 1'b0));
    vq.push_back(idl(1'b0, 32'hA1, 1'b1));
    for (int p = 0; p < 4; p++) vq.push_back(stg(2'(p), 48'h200 + 48'(p), 32'hA1, 1'b1));
    vq.push_back(cmt(5'd31, 32'hA1, 1'b1, 1'b1, 1'b0));
    vq.push_back(idl(1'b0, 32'h8000_00A1, 1'b1));
    vq.push_back(idl(1'b1, 32'h8000_00A1, 1'b0));
    vq.push_back(del(5'd0, 32'h8000_00A0, 1'b1));
    vq.push_back(idl(1'b1, 32'h8000_00A0, 1'b0));
    vq.push_back(del(5'd0, 32'h8000_00A0, 1'b1));
    for (int p = 0; p < 4; p++) vq.push_back(stg(2'(p), 48'h300 + 48'(p), 32'h8000_00A0, 1'b1));
    vq.push_back(clra(32'h0, 1'b1));
    vq.push_back(cmt(5'd1, 32'h0, 1'b1, 1'b0, 1'b1));
    // Read of obj 3 pt 0 across a recommit of obj 3.
    for (int p = 0; p < 4; p++) vq.push_back(stg(2'(p), 48'h111 + 48'(p), 32'h0, 1'b1));
    vq.push_back(cmt(5'd3, 32'h0, 1'b1, 1'b1, 1'b0));
    vq.push_back(idl(1'b0, 32'h8, 1'b1));
    vq.push_back(with_rd(stg(2'd0, 48'hABC, 32'h8, 1'b1), 5'd3, 2'd0, 48'h111));
    for (int p = 1; p < 4; p++)
      vq.push_back(with_rd(stg(2'(p), 48'h222 + 48'(p), 32'h8, 1'b1), 5'd3, 2'd0, 48'h111));
    vq.push_back(with_rd(cmt(5'd3, 32'h8, 1'b1, 1'b1, 1'b0), 5'd3, 2'd0, 48'h111));
    vq.push_back(with_rd(idl(1'b0, 32'h8, 1'b1), 5'd3, 2'd0, 48'h111));
    vq.push_back(with_rd(idl(1'b0, 32'h8, 1'b1), 5'd3, 2'd0, 48'hABC));

    // Reset state, both while held and just after release.
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_model("reset held");
    rst_n = 1'b1;
    #1;
    check_model("reset released");

    foreach (vq[i]) begin
      drv(vq[i].vld, vq[i].op, vq[i].obj, vq[i].pt, vq[i].data, vq[i].clr, vq[i].ra, vq[i].rp);
      tick();
      check($sformatf("vec%0d rdy", i), 64'(bus.cmd_rdy), 64'(vq[i].rdy));
      check($sformatf("vec%0d writing", i), 64'(writing), 64'(vq[i].wr));
      check($sformatf("vec%0d err", i), 64'(bus.cmd_err), 64'(vq[i].err));
      check($sformatf("vec%0d map", i), 64'(obj_map), 64'(vq[i].map));
      check($sformatf("vec%0d changed", i), 64'(changed), 64'(vq[i].chg));
      if (vq[i].chk) check($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(vq[i].rd));
    end

    // Reset asserted while a commit is in flight aborts it and empties staging.
    for (int p = 0; p < 4; p++) begin
      drv(1'b1, 2'b00, 5'd0, 2'(p), 48'h900 + 48'(p), 1'b0, 5'd0, 2'd0);
      tick();
    end
    drv(1'b1, 2'b01, 5'd9, 2'd0, '0, 1'b0, 5'd0, 2'd0);
    tick();
    check_model("in commit");
    drv(1'b0, 2'b00, 5'd0, 2'd0, '0, 1'b0, 5'd0, 2'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("commit aborted");
    #1;
    rst_n = 1'b1;
    drv(1'b1, 2'b01, 5'd9, 2'd0, '0, 1'b0, 5'd0, 2'd0);
    tick();
    check("abort then commit err", 64'(bus.cmd_err), 64'h1);
    check_model("abort then commit");

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int  r;
      logic [1:0] op;
      r = int'($urandom_range(0, 99));
      if (r < 50)      op = 2'b00;
      else if (r < 80) op = 2'b01;
      else if (r < 96) op = 2'b10;
      else             op = 2'b11;
      drv(($urandom_range(0, 9) < 7), op, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          pt_t'({$urandom, $urandom}), ($urandom_range(0, 9) == 0),
          5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    drv(1'b0, 2'b00, 5'd0, 2'd0, '0, 1'b0, 5'd0, 2'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
